// File: rtl/keypad_encoder.sv
// Scanning 4x3 keypad encoder: drives one column at a time, debounces a
// single-row hit, emits one pulse per accepted key and waits for release.
module keypad_encoder #(
    parameter int unsigned SCAN_CYCLES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       clear,
    input  logic [3:0] row,
    output logic [2:0] col,
    output logic [3:0] digit,
    output logic       valid,
    output logic       start,
    output logic       cancel
);

    localparam int unsigned SW = $clog2(SCAN_CYCLES + 1);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {StScan, StDebounce, StEmit, StRelease} state_e;

    state_e        state_q, state_d;
    logic [2:0]    col_q, col_d;
    logic [SW-1:0] dwell_q, dwell_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [3:0]    key_row_q, key_row_d;
    logic [2:0]    key_col_q, key_col_d;
    logic [3:0]    digit_q, digit_d;

    logic          dwell_last;
    logic          cnt_last;
    logic          row_onehot;
    logic          row_match;
    logic          row_idle;
    logic [2:0]    col_next;
    logic [3:0]    r_idx, c_idx;
    logic [3:0]    key_digit;
    logic          key_is_num, key_is_hash, key_is_star;

    assign dwell_last = (dwell_q == SW'(SCAN_CYCLES - 1));
    // Counter reaching DEBOUNCE_CYCLES-1 means this cycle is the final required one
    assign cnt_last   = (cnt_q == DW'(DEBOUNCE_CYCLES - 1));
    assign row_onehot = (row != 4'd0) && ((row & (row - 4'd1)) == 4'd0);
    assign row_match  = (row == key_row_q);
    assign row_idle   = (row == 4'd0);
    assign col_next   = {col_q[1:0], col_q[2]};

    // Decode the latched row/column into a key code
    always_comb begin
        r_idx       = 4'd0;
        c_idx       = 4'd0;
        key_digit   = 4'd0;
        key_is_num  = 1'b0;
        key_is_hash = 1'b0;
        key_is_star = 1'b0;
        unique case (key_row_q)
            4'b0010: r_idx = 4'd1;
            4'b0100: r_idx = 4'd2;
            4'b1000: r_idx = 4'd3;
            default: r_idx = 4'd0;
        endcase
        unique case (key_col_q)
            3'b010:  c_idx = 4'd1;
            3'b100:  c_idx = 4'd2;
            default: c_idx = 4'd0;
        endcase
        if (r_idx == 4'd3) begin
            key_is_star = (c_idx == 4'd0);
            key_is_num  = (c_idx == 4'd1);
            key_is_hash = (c_idx == 4'd2);
            key_digit   = 4'd0;
        end else begin
            key_is_num = 1'b1;
            key_digit  = (r_idx << 1) + r_idx + c_idx + 4'd1;
        end
    end

    // State register
    always_ff @(posedge CLK or posedge clear) begin
        if (clear) begin
            state_q <= StScan;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StScan:     if (dwell_last && row_onehot) state_d = StDebounce;
            StDebounce: begin
                if (!row_match)    state_d = StScan;
                else if (cnt_last) state_d = StEmit;
            end
            StEmit:     state_d = StRelease;
            StRelease:  if (row_idle && cnt_last) state_d = StScan;
            default:    state_d = StScan;
        endcase
    end

    // Datapath next-state: column rotation, counters, key latch, digit
    always_comb begin
        col_d     = col_q;
        dwell_d   = dwell_q;
        cnt_d     = cnt_q;
        key_row_d = key_row_q;
        key_col_d = key_col_q;
        digit_d   = digit_q;
        unique case (state_q)
            StScan: begin
                if (dwell_last) begin
                    dwell_d = '0;
                    if (row_onehot) begin
                        key_row_d = row;
                        key_col_d = col_q;
                        cnt_d     = '0;
                    end else begin
                        col_d = col_next;
                    end
                end else begin
                    dwell_d = dwell_q + SW'(1);
                end
            end
            StDebounce: begin
                if (!row_match) begin
                    col_d   = col_next;
                    dwell_d = '0;
                    cnt_d   = '0;
                end else if (cnt_last) begin
                    cnt_d = '0;
                    // Load digit on entry so it is already visible during the pulse
                    if (key_is_num) digit_d = key_digit;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            StEmit: cnt_d = '0;
            StRelease: begin
                if (!row_idle) begin
                    cnt_d = '0;
                end else if (cnt_last) begin
                    cnt_d   = '0;
                    col_d   = 3'b001;
                    dwell_d = '0;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge CLK or posedge clear) begin
        if (clear) begin
            col_q     <= 3'b001;
            dwell_q   <= '0;
            cnt_q     <= '0;
            key_row_q <= 4'd0;
            key_col_q <= 3'd0;
            digit_q   <= 4'd0;
        end else begin
            col_q     <= col_d;
            dwell_q   <= dwell_d;
            cnt_q     <= cnt_d;
            key_row_q <= key_row_d;
            key_col_q <= key_col_d;
            digit_q   <= digit_d;
        end
    end

    // Outputs: pulses decoded from the single EMIT cycle
    always_comb begin
        col    = col_q;
        digit  = digit_q;
        valid  = (state_q == StEmit) && key_is_num;
        start  = (state_q == StEmit) && key_is_hash;
        cancel = (state_q == StEmit) && key_is_star;
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder with a behavioural keypad matrix model.
module tb_keypad_encoder;

    logic       CLK = 1'b0;
    logic       clear;
    logic [3:0] row;
    logic [2:0] col;
    logic [3:0] digit;
    logic       valid, start, cancel;

    // Keypad model: pressed key drives its row only while its column is driven
    logic       key_down;
    logic [1:0] key_r, key_c;
    logic       force_en;
    logic [3:0] force_row;

    int n_vec = 0;
    int n_err = 0;
    int n_valid = 0, n_start = 0, n_cancel = 0, n_overlap = 0;
    logic [3:0] digits[$];

    int base_v, base_s, base_c;
    logic [2:0] seen;
    int kr[5] = '{0, 1, 1, 2, 3};
    int kc[5] = '{2, 0, 2, 1, 1};
    int kd[5] = '{3, 4, 6, 8, 0};
    int sr[4] = '{0, 0, 2, 2};
    int sc[4] = '{1, 0, 0, 2};
    int sd[4] = '{2, 1, 7, 9};

    keypad_encoder #(
        .SCAN_CYCLES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLK   (CLK),
        .clear (clear),
        .row   (row),
        .col   (col),
        .digit (digit),
        .valid (valid),
        .start (start),
        .cancel(cancel)
    );

    always #5 CLK = ~CLK;

    assign row = force_en ? force_row :
                 ((key_down && (col == (3'b001 << key_c))) ? (4'b0001 << key_r) : 4'b0000);

    // Pulse monitor
    always @(negedge CLK) begin
        if (valid) begin
            n_valid++;
            digits.push_back(digit);
        end
        if (start) n_start++;
        if (cancel) n_cancel++;
        if ((int'(valid) + int'(start) + int'(cancel)) > 1) n_overlap++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c);
        key_r    = r;
        key_c    = c;
        key_down = 1'b1;
    endtask

    task automatic key_cycle(input logic [1:0] r, input logic [1:0] c);
        press(r, c);
        step(20);
        key_down = 1'b0;
        step(20);
    endtask

    initial begin
        clear     = 1'b1;
        key_down  = 1'b0;
        key_r     = 2'd0;
        key_c     = 2'd0;
        force_en  = 1'b0;
        force_row = 4'd0;
        @(negedge CLK);
        #1;
        step(2);
        check("reset_col", col, 3'b001);
        check("reset_digit", digit, 4'd0);
        check("reset_pulses", {valid, start, cancel}, 3'b000);

        // Key '2' held from reset release: sample at cycle 3, pulse at cycle 8
        press(2'd0, 2'd1);
        clear = 1'b0;
        check("resume_col", col, 3'b001);
        step(2);
        check("col_rot_010", col, 3'b010);
        step(5);
        check("no_early_valid", valid, 1'b0);
        check("no_early_count", n_valid, 0);
        step(1);
        check("latency_valid", valid, 1'b1);
        check("latency_digit", digit, 4'd2);
        check("latency_other", {start, cancel}, 2'b00);
        step(1);
        check("pulse_one_cycle", valid, 1'b0);
        check("col_held", col, 3'b010);
        step(11);
        check("no_autorepeat", n_valid, 1);
        key_down = 1'b0;
        step(3);
        check("release_col_held", col, 3'b010);
        step(1);
        check("release_col_001", col, 3'b001);
        step(16);
        check("no_pulse_release", n_valid, 1);

        // Key map coverage
        for (int i = 0; i < 5; i++) begin
            base_v = n_valid;
            key_cycle(2'(kr[i]), 2'(kc[i]));
            check("map_count", n_valid - base_v, 1);
            check("map_digit", digit, 32'(kd[i]));
        end

        // Sequence 2,1,7,9
        base_v = n_valid;
        base_s = n_start;
        base_c = n_cancel;
        digits.delete();
        for (int i = 0; i < 4; i++) key_cycle(2'(sr[i]), 2'(sc[i]));
        check("seq_count", n_valid - base_v, 4);
        for (int i = 0; i < 4; i++) check("seq_digit", digits[i], 32'(sd[i]));
        check("seq_no_start", n_start - base_s, 0);
        check("seq_no_cancel", n_cancel - base_c, 0);

        // '#' then '*'
        base_v = n_valid;
        key_cycle(2'd3, 2'd2);
        check("hash_start", n_start - base_s, 1);
        check("hash_digit", digit, 4'd9);
        check("hash_no_valid", n_valid - base_v, 0);
        key_cycle(2'd3, 2'd0);
        check("star_cancel", n_cancel - base_c, 1);
        check("star_start", n_start - base_s, 1);
        check("star_digit", digit, 4'd9);
        check("star_no_valid", n_valid - base_v, 0);

        // Bounce on '5'
        base_v = n_valid;
        key_r  = 2'd1;
        key_c  = 2'd1;
        for (int i = 0; i < 10; i++) begin
            key_down = ~key_down;
            step(1);
        end
        check("bounce_no_pulse", n_valid - base_v, 0);
        key_down = 1'b1;
        step(20);
        check("bounce_one_pulse", n_valid - base_v, 1);
        check("bounce_digit", digit, 4'd5);
        key_down = 1'b0;
        step(20);

        // Two rows high: no key, scanning continues
        base_v    = n_valid;
        base_s    = n_start;
        base_c    = n_cancel;
        force_en  = 1'b1;
        force_row = 4'b0011;
        seen      = 3'b000;
        for (int i = 0; i < 6; i++) begin
            seen = seen | col;
            step(1);
        end
        step(14);
        check("multi_rotate", seen, 3'b111);
        check("multi_no_pulse", (n_valid - base_v) + (n_start - base_s) + (n_cancel - base_c), 0);
        force_en = 1'b0;
        step(10);

        // clear during DEBOUNCE of '5'
        clear = 1'b1;
        step(2);
        base_v = n_valid;
        press(2'd1, 2'd1);
        clear = 1'b0;
        step(5);
        check("pre_clear_col", col, 3'b010);
        clear = 1'b1;
        #1;
        check("clear_col", col, 3'b001);
        check("clear_digit", digit, 4'd0);
        check("clear_valid", valid, 1'b0);
        step(2);
        check("clear_no_pulse", n_valid - base_v, 0);
        clear = 1'b0;
        step(8);
        check("post_clear_valid", valid, 1'b1);
        check("post_clear_digit", digit, 4'd5);
        step(12);
        key_down = 1'b0;
        step(20);
        check("post_clear_count", n_valid - base_v, 1);

        check("pulse_exclusive", n_overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_encoder.md
KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 Parameter SCAN_CYCLES, default 2: clock cycles each column is driven during scanning (legal range >= 1).
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required to accept a press or a release (legal range >= 1).
REQ-003 Port CLK  input  1: single system clock; all state changes on its rising edge.
REQ-004 Port clear  input  1: asynchronous, active-high reset.
REQ-005 Port row  input  4: keypad row returns, active-high; row[0] is the top row.
REQ-006 Port col  output  3: one-hot active-high column drive; col[0] is the left column.
REQ-007 Port digit  output  4: BCD code of the last accepted numeric key; held between presses.
REQ-008 Port valid  output  1: one-cycle pulse; digit is valid and is to be shifted into the timer.
REQ-009 Port start  output  1: one-cycle pulse on an accepted '#' key.
REQ-010 Port cancel  output  1: one-cycle pulse on an accepted '*' key.

Function
REQ-011 Key map (row,col): row0 = 1,2,3; row1 = 4,5,6; row2 = 7,8,9; row3 = *,0,#.
REQ-012 FSM states: SCAN, DEBOUNCE, EMIT, RELEASE; exactly one state is active at all times.
REQ-013 SCAN: col rotates 001->010->100->001, advancing after SCAN_CYCLES cycles per column.
REQ-014 SCAN: row is sampled on the last dwell cycle of each column.
REQ-015 SCAN: if exactly one row bit is high at the sample, the block latches the row and column, freezes col, and enters DEBOUNCE.
REQ-016 SCAN: zero or multiple row bits high is treated as no key, and scanning continues.
REQ-017 DEBOUNCE: col is held and a counter counts cycles where row equals the latched row.
REQ-018 DEBOUNCE: any mismatching cycle returns to SCAN, with col advancing to the next column.
REQ-019 DEBOUNCE: reaching DEBOUNCE_CYCLES matches enters EMIT; the counter width is ceil(log2(DEBOUNCE_CYCLES+1)) bits, with no wrap.
REQ-020 EMIT lasts exactly one cycle.
REQ-021 EMIT on a numeric key: digit is updated and valid=1 in that same cycle.
REQ-022 EMIT on '#': start=1 and digit is unchanged.
REQ-023 EMIT on '*': cancel=1 and digit is unchanged.
REQ-024 EMIT always proceeds to RELEASE; at most one of valid, start, cancel is high in any cycle.
REQ-025 Latency: the pulse is asserted DEBOUNCE_CYCLES+1 cycles after the SCAN sample that detected the key.
REQ-026 RELEASE: col is held, and the block waits for row==0 on DEBOUNCE_CYCLES consecutive cycles.
REQ-027 RELEASE: any nonzero row restarts the release count; holding a key never produces a second pulse (no auto-repeat).
REQ-028 RELEASE completion returns to SCAN with col=001.
REQ-029 A second key pressed while the first is held is ignored until both keys are released.

Reset
REQ-030 While clear=1: state=SCAN, col=001, digit=0, valid=0, start=0, cancel=0, and all counters are 0.
REQ-031 Assertion of clear mid-debounce or mid-emit takes effect immediately, and no pulse is produced.
REQ-032 After deassertion of clear, scanning resumes at col=001 on the next rising edge.

Verification
REQ-033 Key '2' held for 20 cycles (row=0001 while col=010) -> exactly one valid pulse with digit=2, then no further pulses until release.
REQ-034 Sequence '2','1','7','9', each held 20 cycles and released 20 cycles -> four valid pulses with digits 2,1,7,9 in order, and start=cancel=0 throughout.
REQ-035 Key '#' then '*' -> one start pulse, then one cancel pulse; digit keeps its previous value and valid stays 0.
REQ-036 Bounce: row toggles every cycle for 10 cycles, then is stable for DEBOUNCE_CYCLES -> a single valid pulse and no pulse during the bounce.
REQ-037 Two rows high simultaneously (row=0011) -> no pulse; col keeps rotating.
REQ-038 clear pulsed during DEBOUNCE -> no pulse is produced, col=001 and digit=0 immediately, and a subsequent press of '5' gives valid with digit=5.
